manchester_tx: RTL and testbench



---
 rtl/manchester_pkg.sv | 19 +
 rtl/manchester_tx_hold.sv | 34 +++
 rtl/manchester_tx.sv | 137 +++++++++++++
 tb/tb_manchester_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/manchester_pkg.sv
// Shared Manchester line definitions for the transmitter and receiver.
// The symbol timing constants live here so that both ends agree on them.
package manchester_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2
    } state_t;

    localparam int SAMPLES_PER_BIT = 16;
    localparam int HALF_BIT        = 8;

    // First half of a bit carries the bit value, second half its complement.
    function automatic logic line_level(input logic b, input logic [3:0] phase);
        return b ^ (phase >= 4'(HALF_BIT));
    endfunction

endpackage

// File: rtl/manchester_tx_hold.sv
// Single-entry holding register between the valid/ready port and the shifter.
// The handshake is not qualified by the sample enable.
module manchester_tx_hold (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    input  logic       load,
    output logic       ready,
    output logic       full,
    output logic       full_next,
    output logic [7:0] q
);

    logic accept;

    assign accept    = valid && ready;
    // A load and an accept never coincide because ready is low while full.
    assign full_next = accept || (full && !load);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full  <= 1'b0;
            ready <= 1'b1;
            q     <= '0;
        end else begin
            full  <= full_next;
            ready <= !full_next;
            if (accept)
                q <= data;
        end
    end

endmodule

// File: rtl/manchester_tx.sv
// Manchester transmitter: alternating preamble, then bytes MSB first,
// 16 enabled sample clocks per bit, back-to-back bytes without a gap.
module manchester_tx
    import manchester_pkg::*;
#(
    parameter int PREAMBLE_BITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       mout,
    output logic       mout_en,
    output logic       sync,
    output logic       busy
);

    localparam logic [3:0] LAST_PHASE = 4'(SAMPLES_PER_BIT - 1);
    localparam logic [3:0] LAST_PRE   = 4'(PREAMBLE_BITS - 1);
    localparam logic [3:0] LAST_DATA  = 4'd7;

    state_t     state, state_n;
    logic [3:0] phase, phase_n;
    logic [3:0] bit_idx, bit_n;
    logic [7:0] shifter, shift_n;
    logic       load, bit_end, mout_n, sync_n;
    logic       hold_full, hold_full_n;
    logic [7:0] hold_q;

    manchester_tx_hold u_hold (
        .clk       (clk),
        .reset     (reset),
        .data      (tx_data),
        .valid     (tx_valid),
        .load      (load),
        .ready     (tx_ready),
        .full      (hold_full),
        .full_next (hold_full_n),
        .q         (hold_q)
    );

    assign bit_end = (phase == LAST_PHASE);

    always_comb begin
        state_n = state;
        phase_n = phase;
        bit_n   = bit_idx;
        shift_n = shifter;
        load    = 1'b0;
        sync_n  = 1'b0;
        if (enable) begin
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        phase_n = 4'd0;
                        bit_n   = 4'd0;
                        if (PREAMBLE_BITS == 0) begin
                            state_n = DATA;
                            load    = 1'b1;
                            shift_n = hold_q;
                        end else begin
                            state_n = PREAMBLE;
                        end
                    end
                end
                PREAMBLE: begin
                    phase_n = phase + 4'd1;
                    if (bit_end) begin
                        if (bit_idx == LAST_PRE) begin
                            state_n = DATA;
                            bit_n   = 4'd0;
                            load    = 1'b1;
                            shift_n = hold_q;
                        end else begin
                            bit_n = bit_idx + 4'd1;
                        end
                    end
                end
                DATA: begin
                    phase_n = phase + 4'd1;
                    if (bit_end) begin
                        sync_n = 1'b1;
                        if (bit_idx == LAST_DATA) begin
                            bit_n = 4'd0;
                            if (hold_full) begin
                                load    = 1'b1;
                                shift_n = hold_q;
                            end else begin
                                state_n = IDLE;
                            end
                        end else begin
                            bit_n   = bit_idx + 4'd1;
                            shift_n = {shifter[6:0], 1'b0};
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // The line level is registered from the next-state view so it lines up
    // with the phase being entered at this edge.
    always_comb begin
        mout_n = 1'b0;
        case (state_n)
            PREAMBLE: mout_n = line_level(~bit_n[0], phase_n);
            DATA:     mout_n = line_level(shift_n[7], phase_n);
            default:  mout_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= 4'd0;
            bit_idx <= 4'd0;
            shifter <= 8'd0;
            mout    <= 1'b0;
            mout_en <= 1'b0;
            sync    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_idx <= bit_n;
            shifter <= shift_n;
            mout    <= mout_n;
            mout_en <= (state_n != IDLE);
            sync    <= sync_n;
            busy    <= (state_n != IDLE) || hold_full_n;
        end
    end

endmodule

// File: tb/tb_manchester_tx.sv
// Bench for manchester_tx: two instances (2 and 0 preamble bits) on shared
// inputs, each tracked by a frame-position model and a few literal checks.
module tb_manchester_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       rdy0, mo0, me0, sy0, bz0;
    logic       rdy1, mo1, me1, sy1, bz1;

    always #5 clk = ~clk;

    manchester_tx #(.PREAMBLE_BITS(2)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(rdy0), .mout(mo0), .mout_en(me0),
        .sync(sy0), .busy(bz0)
    );

    manchester_tx #(.PREAMBLE_BITS(0)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(rdy1), .mout(mo1), .mout_en(me1),
        .sync(sy1), .busy(bz1)
    );

    // Model state: k is the index of the symbol on the line within the
    // current segment (preamble + first byte, or a chained byte).
    typedef struct packed {
        logic       inf;
        int         k;
        int         plen;
        logic [7:0] cur;
        logic       hfull;
        logic [7:0] hb;
        logic       sync;
    } ms_t;

    ms_t m0 = '0;
    ms_t m1 = '0;

    function automatic ms_t mstep(input ms_t s, input int p, input logic en,
                                  input logic v, input logic [7:0] d);
        ms_t  n = s;
        logic old_hold = s.hfull;
        n.sync = 1'b0;
        if (en) begin
            if (s.inf) begin
                n.sync = (s.k >= s.plen) && (((s.k - s.plen) % 16) == 15);
                if (s.k + 1 < s.plen + 128) begin
                    n.k = s.k + 1;
                    if (n.k == s.plen) begin
                        n.cur   = s.hb;
                        n.hfull = 1'b0;
                    end
                end else if (old_hold) begin
                    n.plen  = 0;
                    n.k     = 0;
                    n.cur   = s.hb;
                    n.hfull = 1'b0;
                end else begin
                    n.inf = 1'b0;
                end
            end else if (old_hold) begin
                n.inf  = 1'b1;
                n.k    = 0;
                n.plen = p * 16;
                if (p == 0) begin
                    n.cur   = s.hb;
                    n.hfull = 1'b0;
                end
            end
        end
        if (v && !old_hold) begin
            n.hfull = 1'b1;
            n.hb    = d;
        end
        return n;
    endfunction

    // {mout, mout_en, sync, tx_ready, busy}
    function automatic logic [4:0] mexp(input ms_t s);
        logic lvl = 1'b0;
        int   j;
        if (s.inf) begin
            if (s.k < s.plen) begin
                lvl = (((s.k / 16) % 2) == 0) ^ ((s.k % 16) >= 8);
            end else begin
                j   = s.k - s.plen;
                lvl = s.cur[7 - j / 16] ^ ((j % 16) >= 8);
            end
        end
        return {lvl, s.inf, s.sync, !s.hfull, s.inf || s.hfull};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m0 <= '0;
            m1 <= '0;
        end else begin
            m0 <= mstep(m0, 2, enable, tx_valid, tx_data);
            m1 <= mstep(m1, 0, enable, tx_valid, tx_data);
        end
    end

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int en_mode = 0;
    int en0_cnt = 0, en1_cnt = 0, sync0_cnt = 0, rise0 = 0;
    logic me0_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        check("dut0 outputs", 32'({mo0, me0, sy0, rdy0, bz0}), 32'(mexp(m0)));
        check("dut1 outputs", 32'({mo1, me1, sy1, rdy1, bz1}), 32'(mexp(m1)));
        en0_cnt   += int'(me0);
        en1_cnt   += int'(me1);
        sync0_cnt += int'(sy0);
        rise0     += int'(me0 && !me0_prev);
        me0_prev   = me0;
        case (en_mode)
            0:       enable = 1'b1;
            1:       enable = ((cyc % 4) == 0);
            default: enable = ($urandom_range(0, 2) != 0);
        endcase
        cyc++;
    endtask

    // Leaves tx_valid high so the caller can chain another byte.
    task automatic send(input logic [7:0] b);
        bit done = 1'b0;
        tx_valid = 1'b1;
        tx_data  = b;
        for (int i = 0; i < 4000 && !done; i++) begin
            if (rdy0) done = 1'b1;
            tick();
        end
        check("send handshake", 32'(done), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 6000 && (bz0 || bz1); i++) tick();
        check("drain idle", 32'({bz0, bz1}), 32'd0);
    endtask

    initial begin
        int e0, e1, s0, r0, bad, idx;
        logic [9:0] pat;
        logic exp_lvl;

        #1 reset = 1'b1;
        #1;
        check("reset state dut0", 32'({mo0, me0, sy0, rdy0, bz0}), 32'b00010);
        check("reset state dut1", 32'({mo1, me1, sy1, rdy1, bz1}), 32'b00010);
        en_mode = 0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();

        // Single byte 0xA5: preamble 1,0 then 1010_0101.
        e0 = en0_cnt; e1 = en1_cnt; s0 = sync0_cnt;
        send(8'hA5);
        tx_valid = 1'b0;
        pat = 10'b10_1010_0101;
        bad = 0; idx = 0;
        for (int c = 0; c < 175; c++) begin
            tick();
            if (me0) begin
                exp_lvl = pat[9 - idx / 16] ^ ((idx % 16) >= 8);
                if (idx < 160 && mo0 !== exp_lvl) bad++;
                idx++;
            end
        end
        check("A5 waveform mismatches", 32'(bad), 32'd0);
        check("A5 mout_en clks", 32'(en0_cnt - e0), 32'd160);
        check("A5 sync pulses", 32'(sync0_cnt - s0), 32'd8);
        check("A5 no-preamble mout_en clks", 32'(en1_cnt - e1), 32'd128);
        drain();

        // 0x00 without preamble: first half-bit low right after start.
        e0 = en0_cnt; e1 = en1_cnt;
        send(8'h00);
        tx_valid = 1'b0;
        tick();
        check("P0 first half-bit", 32'({mo1, me1}), 32'b01);
        check("P2 first half-bit", 32'({mo0, me0}), 32'b11);
        drain();
        check("00 no-preamble clks", 32'(en1_cnt - e1), 32'd128);
        check("00 preamble clks", 32'(en0_cnt - e0), 32'd160);

        // Back-to-back bytes share one preamble and have no gap.
        e0 = en0_cnt; s0 = sync0_cnt; r0 = rise0;
        send(8'hA5);
        send(8'h3C);
        tx_valid = 1'b0;
        drain();
        check("b2b mout_en clks", 32'(en0_cnt - e0), 32'd288);
        check("b2b frame count", 32'(rise0 - r0), 32'd1);
        check("b2b sync pulses", 32'(sync0_cnt - s0), 32'd16);

        // Handshake on the edge that ends the last bit, hold empty.
        send(8'h5A);
        tx_valid = 1'b0;
        repeat (160) tick();
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        tick();
        tx_valid = 1'b0;
        check("final-edge mout_en drop", 32'(me0), 32'd0);
        check("final-edge busy/ready", 32'({bz0, rdy0}), 32'b10);
        tick();
        check("final-edge new preamble", 32'({mo0, me0}), 32'b11);
        drain();

        // Enable 1 clk in 4, handshake on a disabled edge.
        en_mode = 1;
        for (int i = 0; i < 8 && enable; i++) tick();
        e0 = en0_cnt; e1 = en1_cnt; s0 = sync0_cnt;
        send(8'hFF);
        tx_valid = 1'b0;
        drain();
        check("slow mout_en clks", 32'(en0_cnt - e0), 32'd640);
        check("slow no-preamble clks", 32'(en1_cnt - e1), 32'd512);
        check("slow sync pulses", 32'(sync0_cnt - s0), 32'd8);

        // Reset mid-byte aborts the frame immediately.
        en_mode = 0;
        tick();
        send(8'h96);
        tx_valid = 1'b0;
        repeat (50) tick();
        #2 reset = 1'b1;
        #1;
        check("mid reset dut0", 32'({mo0, me0, sy0, rdy0, bz0}), 32'b00010);
        check("mid reset dut1", 32'({mo1, me1, sy1, rdy1, bz1}), 32'b00010);
        tick(); tick();
        reset = 1'b0;
        tick();
        send(8'h81);
        tx_valid = 1'b0;
        tick();
        check("restart with preamble", 32'({mo0, me0}), 32'b11);
        drain();

        // Randomized traffic and enable.
        en_mode = 2;
        for (int i = 0; i < 4000; i++) begin
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
            if ((i % 700) == 699) en_mode = (en_mode == 2) ? 0 : 2;
            tick();
        end
        tx_valid = 1'b0;
        en_mode  = 0;
        tick();
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
